// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide unit.
// The EX stage drives the master side; muldiv_unit drives the slave side.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, wr_hi, wr_lo, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, wr_hi, wr_lo, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO: shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to execute MULT/MULTU through a single-cycle multiplier instead.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(ITERS);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         op_q;
    logic               sa_q;
    logic               sb_q;
    logic               dz_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   mb_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    logic               start_signed;
    logic [WIDTH-1:0]   start_ma;
    logic [WIDTH-1:0]   start_mb;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_d;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_d;
    logic [2*WIDTH-1:0] acc_d;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                             input logic is_signed);
        logic signed [WIDTH-1:0] n;
        n = -v;
        return (is_signed && v[WIDTH-1]) ? $unsigned(n) : $unsigned(v);
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_dw(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    always_comb begin
        start_signed = ~bus.op[0];
        start_ma     = mag(bus.a, start_signed);
        start_mb     = mag(bus.b, start_signed);

        // Multiply: multiplier sits in acc low half, partial product shifts in from the top.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : '0);
        mul_d   = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: acc = {remainder, dividend/quotient}; shift one dividend bit into the remainder.
        div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_sh - {1'b0, mb_q};
        if (div_sh >= {1'b0, mb_q}) begin
            div_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end

        acc_d = op_q[1] ? div_d : mul_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            a_q     <= '0;
            mb_q    <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;

            // MTHI/MTLO only land while idle; a result write can never coincide.
            if (!busy_q) begin
                if (bus.wr_hi) hi_q <= bus.wdata;
                if (bus.wr_lo) lo_q <= bus.wdata;
            end

            if (bus.flush) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            op_q    <= bus.op;
                            sa_q    <= start_signed & bus.a[WIDTH-1];
                            sb_q    <= start_signed & bus.b[WIDTH-1];
                            dz_q    <= bus.op[1] & (bus.b == '0);
                            a_q     <= bus.a;
                            mb_q    <= start_mb;
                            acc_q   <= {{WIDTH{1'b0}}, start_ma};
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
`ifdef MULDIV_FAST_MUL_EN
                            if (!bus.op[1]) begin
                                acc_q   <= {{WIDTH{1'b0}}, start_ma} * {{WIDTH{1'b0}}, start_mb};
                                state_q <= SIGN;
                            end
`endif
                        end
                    end
                    CALC: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(ITERS - 1)) state_q <= SIGN;
                    end
                    SIGN: begin
                        if (op_q[1]) begin
                            if (dz_q) begin
                                lo_q <= '1;
                                hi_q <= a_q;
                            end else begin
                                lo_q <= neg_w(acc_q[WIDTH-1:0], sa_q ^ sb_q);
                                hi_q <= neg_w(acc_q[2*WIDTH-1:WIDTH], sa_q);
                            end
                        end else begin
                            {hi_q, lo_q} <= neg_dw(acc_q, sa_q ^ sb_q);
                        end
                        done_q  <= 1'b1;
                        dbz_q   <= dz_q;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed HI/LO results and latencies.
module tb_muldiv_unit;
    logic clk;
    logic rst_n;
    int   err_cnt;
    int   chk_cnt;
    int   lat;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives start from the current time; returns edges counted from the start edge to done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int n);
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 1;
        check("busy_after_start", bus.busy, 1);
        while (!bus.done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        err_cnt   = 0;
        chk_cnt   = 0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wdata = '0;
        rst_n     = 1'b0;

        #2;
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MULTU max*max
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("multu_lat", lat, MUL_LAT);
        check("multu_hi", bus.hi, 64'hFFFF_FFFE);
        check("multu_lo", bus.lo, 64'h0000_0001);
        @(posedge clk);
        #1;
        check("multu_done_pulse", bus.done, 0);

        // MULT -7 * 3
        run_op(2'b00, 32'hFFFF_FFF9, 32'd3, lat);
        check("mult_lat", lat, MUL_LAT);
        check("mult_hi", bus.hi, 64'hFFFF_FFFF);
        check("mult_lo", bus.lo, 64'hFFFF_FFEB);

        // DIV -7 / 2
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_lat", lat, DIV_LAT);
        check("div_lo", bus.lo, 64'hFFFF_FFFD);
        check("div_hi", bus.hi, 64'hFFFF_FFFF);
        check("div_dbz", bus.div_by_zero, 0);

        // DIVU 100 / 0
        run_op(2'b11, 32'd100, 32'd0, lat);
        check("dz_lat", lat, DIV_LAT);
        check("dz_lo", bus.lo, 64'hFFFF_FFFF);
        check("dz_hi", bus.hi, 64'd100);
        check("dz_flag", bus.div_by_zero, 1);
        @(posedge clk);
        #1;
        check("dz_flag_clear", bus.div_by_zero, 0);
        check("dz_done_clear", bus.done, 0);

        // DIV overflow case, then back-to-back start in the done cycle
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("ovf_lat", lat, DIV_LAT);
        check("ovf_lo", bus.lo, 64'h8000_0000);
        check("ovf_hi", bus.hi, 64'h0);
        check("ovf_dbz", bus.div_by_zero, 0);
        run_op(2'b01, 32'd3, 32'd5, lat);
        check("b2b_lat", lat, MUL_LAT);
        check("b2b_lo", bus.lo, 64'd15);
        check("b2b_hi", bus.hi, 64'd0);

        // MTLO, then DIVU flushed mid-CALC with an MTHI attempted while busy
        @(posedge clk);
        #1;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'h1234;
        @(posedge clk);
        #1;
        bus.wr_lo = 1'b0;
        check("mtlo", bus.lo, 64'h1234);
        bus.op    = 2'b11;
        bus.a     = 32'd9;
        bus.b     = 32'd4;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("flush_busy_start", bus.busy, 1);
        for (int i = 0; i < 10; i++) begin
            bus.wr_hi = (i == 3);
            bus.wdata = 32'hDEAD_BEEF;
            @(posedge clk);
            #1;
        end
        bus.wr_hi = 1'b0;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 0);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) lat++;
            @(posedge clk);
            #1;
        end
        check("flush_no_done", lat, 0);
        check("flush_lo", bus.lo, 64'h1234);
        check("flush_hi", bus.hi, 64'd0);

        // Async reset mid-CALC
        bus.op    = 2'b01;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_lo", bus.lo, 64'd0);
        check("arst_hi", bus.hi, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // start together with flush is dropped
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("sf_busy", bus.busy, 0);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done || bus.busy) lat++;
            @(posedge clk);
            #1;
        end
        check("sf_idle", lat, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
